bus_arbiter: RTL and testbench

Two-master bus arbiter and access sequencer sitting between the front-end processing unit's bus controller and the back-end (memory/IO) bus. Master 0 is the CPU load/store port; master 1 is a secondary requester (LED/segment refresh engine or DMA). The block grants the single back-end bus round-robin, decodes a one-hot device select from the address, holds each access for a fixed number of wait cycles, and returns read data with a one-cycle completion pulse.

---
 rtl/bus_arbiter_pkg.sv | 22 ++
 rtl/bus_arbiter_rr.sv | 38 +++
 rtl/bus_arbiter.sv | 156 +++++++++++++++
 tb/tb_bus_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// bus_arbiter_pkg
//   Shared types and constants for the two-master back-end bus arbiter.
//   - state_t  : access sequencer states (idle / bus driven / completion)
//   - SEL_LSB  : lowest address bit of the device-select field
//   - SEL_W    : width of the device-select field (2**SEL_W devices)
//   - CNT_W    : width of the wait-cycle counter (covers 1..15 wait cycles)
// ---------------------------------------------------------------------------
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int SEL_LSB = 8;
    localparam int SEL_W   = 5;
    localparam int DEV_N   = 1 << SEL_W;
    localparam int CNT_W   = 4;

endpackage

// File: rtl/bus_arbiter_rr.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
//   Two-way round-robin pick. Holds the "last granted" pointer; on a tie the
//   master that did not win last time is picked. The pointer only moves when
//   the caller actually takes the pick.
//   Ports:
//     clk, rst   : clock, synchronous active-low reset (last -> 1, so that
//                  master 0 wins the first tie after reset)
//     req[1:0]   : request vector, bit i = master i
//     take       : caller consumes the pick this cycle
//     pick_vld   : at least one request is present
//     pick       : index of the chosen master
// ---------------------------------------------------------------------------
module rr_arbiter2
    import bus_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic       pick_vld,
    output logic       pick
);

    logic last;

    always_comb begin
        pick_vld = |req;
        if (&req) pick = ~last;
        else      pick = req[1];
    end

    always_ff @(posedge clk) begin
        if (!rst)                  last <= 1'b1;
        else if (take && pick_vld) last <= pick;
    end

endmodule

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//   Grants the single back-end bus to one of two masters (round-robin on
//   ties), drives the access for WAIT_CYCLES cycles with a one-hot device
//   select decoded from addr[12:8], then pulses the winner's done for one
//   cycle. Read data is captured on the last driven cycle and held in
//   m_rdata until the next read completes.
//   Parameters:
//     WAIT_CYCLES : cycles the bus is driven per access, 1..15
//   Ports:
//     clk, rst                   : clock, synchronous active-low reset
//     m0_*/m1_* req,we,addr,wdata: master request inputs (sampled in idle only)
//     m0_gnt, m1_gnt             : master owns the bus (access and done)
//     m0_done, m1_done           : one-cycle completion pulse
//     m_rdata                    : shared read data, held between reads
//     bus_select/w/addr/wdata    : back-end bus, all zero outside access
//     bus_rdata                  : back-end read data (combinational)
//   Every output is a function of registered state only.
// ---------------------------------------------------------------------------
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic        m0_done,
    output logic        m1_done,
    output logic [31:0] m_rdata,
    output logic [31:0] bus_select,
    output logic        bus_w,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata
);

    state_t             state, state_nx;
    logic               owner;
    logic               we_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        rdata_q;
    logic [CNT_W-1:0]   wait_cnt;

    logic               pick_vld;
    logic               pick;
    logic               take;

    // The arbiter only commits a pick while we are idle; requests seen during
    // an access are ignored until the sequencer returns to idle.
    assign take = (state == ST_IDLE);

    rr_arbiter2 u_rr (
        .clk      (clk),
        .rst      (rst),
        .req      ({m1_req, m0_req}),
        .take     (take),
        .pick_vld (pick_vld),
        .pick     (pick)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nx;
    end

    // ---------------- next state ----------------
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (pick_vld)        state_nx = ST_ACCESS;
            ST_ACCESS: if (wait_cnt == '0)  state_nx = ST_DONE;
            ST_DONE:                        state_nx = ST_IDLE;
            default:                        state_nx = ST_IDLE;
        endcase
    end

    // ---------------- request latch, counter, read capture ----------------
    // The winner's request is copied at grant so later input changes from
    // either master cannot disturb the access in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            owner    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wait_cnt <= '0;
            rdata_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        owner    <= pick;
                        we_q     <= pick ? m1_we    : m0_we;
                        addr_q   <= pick ? m1_addr  : m0_addr;
                        wdata_q  <= pick ? m1_wdata : m0_wdata;
                        wait_cnt <= CNT_W'(WAIT_CYCLES - 1);
                    end
                end
                ST_ACCESS: begin
                    if (wait_cnt == '0) begin
                        // last driven cycle: the back end has had the full
                        // wait budget to settle, so this is the only sample
                        if (!we_q) rdata_q <= bus_rdata;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- outputs (decoded from registered state) ----------------
    always_comb begin
        m0_gnt     = 1'b0;
        m1_gnt     = 1'b0;
        m0_done    = 1'b0;
        m1_done    = 1'b0;
        bus_select = '0;
        bus_w      = 1'b0;
        bus_addr   = '0;
        bus_wdata  = '0;

        if (state == ST_ACCESS || state == ST_DONE) begin
            m0_gnt = ~owner;
            m1_gnt =  owner;
        end

        if (state == ST_DONE) begin
            m0_done = ~owner;
            m1_done =  owner;
        end

        if (state == ST_ACCESS) begin
            bus_select[addr_q[SEL_LSB +: SEL_W]] = 1'b1;
            bus_w     = we_q;
            bus_addr  = addr_q;
            bus_wdata = wdata_q;
        end
    end

    assign m_rdata = rdata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Two arbiters side by side (WAIT_CYCLES 1 and 3) share one set of master
// inputs. A transaction-level model predicts each grant at the edge it
// happens and queues the expected access; a negedge monitor compares every
// output against the queue front and retires entries on completion.
module tb_bus_arbiter;

    localparam int NDUT = 2;

    typedef struct {
        int          start;   // edge at which the grant was taken
        logic        m;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        m0_req, m1_req, m0_we, m1_we;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic        use_ovr;
    logic [31:0] ovr_val;

    logic        m0_gnt_a [NDUT];
    logic        m1_gnt_a [NDUT];
    logic        m0_done_a[NDUT];
    logic        m1_done_a[NDUT];
    logic        bus_w_a  [NDUT];
    logic [31:0] m_rdata_a[NDUT];
    logic [31:0] bus_sel_a[NDUT];
    logic [31:0] bus_addr_a[NDUT];
    logic [31:0] bus_wdata_a[NDUT];
    logic [31:0] bus_rdata_a[NDUT];

    function automatic logic [31:0] hash(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    function automatic int wait_of(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int W = (g == 0) ? 1 : 3;
        assign bus_rdata_a[g] = use_ovr ? ovr_val : hash(bus_addr_a[g]);
        bus_arbiter #(.WAIT_CYCLES(W)) dut (
            .clk(clk), .rst(rst),
            .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
            .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
            .m0_gnt(m0_gnt_a[g]), .m1_gnt(m1_gnt_a[g]),
            .m0_done(m0_done_a[g]), .m1_done(m1_done_a[g]),
            .m_rdata(m_rdata_a[g]),
            .bus_select(bus_sel_a[g]), .bus_w(bus_w_a[g]),
            .bus_addr(bus_addr_a[g]), .bus_wdata(bus_wdata_a[g]),
            .bus_rdata(bus_rdata_a[g])
        );
    end

    int checks = 0;
    int failures = 0;

    // ---------------- reference model (runs on each rising edge) ----------------
    exp_t q0[$];
    exp_t q1[$];
    int   ecnt = 0;
    int   rst_edge = -1;
    int   free_edge[NDUT];
    logic last_m[NDUT];
    exp_t it_m;
    int   wm;

    initial begin
        for (int g = 0; g < NDUT; g++) begin
            free_edge[g] = 0;
            last_m[g] = 1'b1;
        end
        forever begin
            @(posedge clk);
            ecnt++;
            if (!rst) rst_edge = ecnt;
            for (int g = 0; g < NDUT; g++) begin
                wm = wait_of(g);
                if (!rst) begin
                    if (g == 0) q0.delete(); else q1.delete();
                    last_m[g] = 1'b1;
                    free_edge[g] = ecnt + 1;
                end else if (ecnt >= free_edge[g] && (m0_req || m1_req)) begin
                    if (m0_req && m1_req) it_m.m = ~last_m[g];
                    else                  it_m.m = m1_req;
                    last_m[g]    = it_m.m;
                    it_m.start   = ecnt;
                    it_m.we      = it_m.m ? m1_we    : m0_we;
                    it_m.addr    = it_m.m ? m1_addr  : m0_addr;
                    it_m.wdata   = it_m.m ? m1_wdata : m0_wdata;
                    it_m.rdata   = use_ovr ? ovr_val : hash(it_m.addr);
                    if (g == 0) q0.push_back(it_m); else q1.push_back(it_m);
                    free_edge[g] = ecnt + wm + 2;
                end
            end
        end
    end

    // ---------------- monitor (runs on each falling edge) ----------------
    logic [31:0] mon_rd[NDUT];
    exp_t        it_c;
    logic        have, do_pop;
    int          wc;
    logic        e_g0, e_g1, e_d0, e_d1, e_w;
    logic [31:0] e_sel, e_addr, e_wd;
    logic [100:0] exp_v, act_v;

    initial begin
        for (int g = 0; g < NDUT; g++) mon_rd[g] = '0;
        forever begin
            @(negedge clk);
            if (ecnt >= 1) begin
                for (int g = 0; g < NDUT; g++) begin
                    wc = wait_of(g);
                    if (rst_edge == ecnt) mon_rd[g] = '0;
                    have = (g == 0) ? (q0.size() > 0) : (q1.size() > 0);
                    if (have) it_c = (g == 0) ? q0[0] : q1[0];
                    {e_g0, e_g1, e_d0, e_d1, e_w} = '0;
                    e_sel = '0; e_addr = '0; e_wd = '0;
                    do_pop = 1'b0;
                    if (have && ecnt >= it_c.start && ecnt < it_c.start + wc) begin
                        e_g0   = ~it_c.m;
                        e_g1   =  it_c.m;
                        e_w    = it_c.we;
                        e_sel  = 32'h1 << it_c.addr[12:8];
                        e_addr = it_c.addr;
                        e_wd   = it_c.wdata;
                    end else if (have && ecnt == it_c.start + wc) begin
                        e_g0 = ~it_c.m; e_d0 = ~it_c.m;
                        e_g1 =  it_c.m; e_d1 =  it_c.m;
                        do_pop = 1'b1;
                        if (!it_c.we) mon_rd[g] = it_c.rdata;
                    end
                    exp_v = {e_g0, e_g1, e_d0, e_d1, e_w, e_sel, e_addr, e_wd};
                    act_v = {m0_gnt_a[g], m1_gnt_a[g], m0_done_a[g], m1_done_a[g],
                             bus_w_a[g], bus_sel_a[g], bus_addr_a[g], bus_wdata_a[g]};
                    checks++;
                    if (act_v !== exp_v) begin
                        failures++;
                        $display("FAIL outputs dut%0d edge=%0d got=%h exp=%h (gnt0,gnt1,done0,done1,w,sel,addr,wdata)",
                                 g, ecnt, act_v, exp_v);
                    end
                    checks++;
                    if (m_rdata_a[g] !== mon_rd[g]) begin
                        failures++;
                        $display("FAIL m_rdata dut%0d edge=%0d got=%h exp=%h",
                                 g, ecnt, m_rdata_a[g], mon_rd[g]);
                    end
                    if (do_pop || ((m0_done_a[g] || m1_done_a[g]) && have)) begin
                        if (g == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        rst = 1'b0;
        use_ovr = 1'b0; ovr_val = '0;
        m0_we = 1'b0; m1_we = 1'b0;
        m0_addr = 32'h0000_0A10; m1_addr = 32'h0000_0B20;
        m0_wdata = 32'h1111_1111; m1_wdata = 32'h2222_2222;
        // reset held two edges with both masters requesting
        m0_req = 1'b1; m1_req = 1'b1;
        step(); step();
        rst = 1'b1;
        // contention: both held high, grants must alternate starting with 0
        repeat (40) step();
        idle(8);

        // single read returning a fixed pattern
        use_ovr = 1'b1; ovr_val = 32'hDEAD_BEEF;
        m0_we = 1'b0; m0_addr = 32'h0000_0304;
        m0_req = 1'b1;
        repeat (6) step();
        idle(8);
        use_ovr = 1'b0;

        // write to the top device, must not touch m_rdata
        m1_we = 1'b1; m1_addr = 32'h0000_1F00; m1_wdata = 32'h1234_5678;
        m1_req = 1'b1;
        repeat (5) step();
        idle(8);

        // reset during the second driven cycle of the 3-wait instance
        m0_we = 1'b0; m0_addr = 32'h0000_0540;
        m0_req = 1'b1;
        step();               // grant edge N
        step();               // edge N+1
        rst = 1'b0; m0_req = 1'b0;
        step();               // edge N+2 sees reset
        rst = 1'b1;
        m0_req = 1'b1;
        repeat (5) step();
        idle(8);

        // request dropped right after grant: access still completes once
        m0_we = 1'b1; m0_addr = 32'h0000_0220; m0_wdata = 32'hCAFE_0001;
        m0_req = 1'b1;
        step();
        m0_req = 1'b0;
        m0_addr = 32'hFFFF_FFFF; m0_wdata = 32'h0;
        idle(8);

        // randomized traffic, inputs change freely under an access
        repeat (500) begin
            step();
            if ($urandom_range(3) == 0) m0_req = ~m0_req;
            if ($urandom_range(3) == 0) m1_req = ~m1_req;
            m0_we = 1'($urandom_range(1));
            m1_we = 1'($urandom_range(1));
            m0_addr = $urandom();
            m1_addr = $urandom();
            m0_wdata = $urandom();
            m1_wdata = $urandom();
            rst = ($urandom_range(99) != 0);
        end
        rst = 1'b1;
        idle(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
